calc_method_select: RTL

CALC_METHOD_SELECT -- requirements
Module: calc_method_select

---
 rtl/calc_method_select_if.sv | 31 +++
 rtl/calc_method_select.sv | 115 +++++++++++
 2 files changed

// File: rtl/calc_method_select_if.sv
// Signal bundle between the front-panel buttons / calculation controller and the
// method selector: raw button levels and clear in, selection state out.
interface calc_method_select_if;
    logic       btn_next;
    logic       btn_prev;
    logic       btn_confirm;
    logic       clear;
    logic [2:0] method_sel;
    logic       method_valid;
    logic       locked;

    modport master (
        output btn_next,
        output btn_prev,
        output btn_confirm,
        output clear,
        input  method_sel,
        input  method_valid,
        input  locked
    );

    modport slave (
        input  btn_next,
        input  btn_prev,
        input  btn_confirm,
        input  clear,
        output method_sel,
        output method_valid,
        output locked
    );
endinterface

// File: rtl/calc_method_select.sv
// Calculation method selector: three synchronized, debounced push-buttons step a
// wrapping method index and lock it in; the calculation controller unlocks via clear.
module calc_method_select #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int NUM_METHODS     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    calc_method_select_if.slave  bus
);

    localparam int BTN_NEXT    = 0;
    localparam int BTN_PREV    = 1;
    localparam int BTN_CONFIRM = 2;
    localparam int NUM_BTNS    = 3;

    localparam int                CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]        SEL_LAST = 3'(NUM_METHODS - 1);

    typedef enum logic {
        SELECT = 1'b0,
        LOCKED = 1'b1
    } state_t;

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] press;

    assign btn_raw[BTN_NEXT]    = bus.btn_next;
    assign btn_raw[BTN_PREV]    = bus.btn_prev;
    assign btn_raw[BTN_CONFIRM] = bus.btn_confirm;

    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
        logic             sync1_reg;
        logic             sync2_reg;
        logic             level_reg;
        logic             press_reg;
        logic [CNT_W-1:0] cnt_reg;

        // The press pulse is raised on the same edge that the debounced level rises,
        // so a release (1->0 acceptance) never produces a pulse.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_reg <= 1'b0;
                sync2_reg <= 1'b0;
                level_reg <= 1'b0;
                press_reg <= 1'b0;
                cnt_reg   <= '0;
            end else begin
                sync1_reg <= btn_raw[gi];
                sync2_reg <= sync1_reg;
                press_reg <= 1'b0;
                if (sync2_reg == level_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_reg   <= '0;
                    level_reg <= sync2_reg;
                    press_reg <= sync2_reg;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end

        assign press[gi] = press_reg;
    end

    state_t     state_reg, state_next;
    logic [2:0] sel_reg, sel_next;
    logic       valid_reg, valid_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= SELECT;
            sel_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            valid_reg <= valid_next;
        end
    end

    // Confirm outranks next/prev; opposing next+prev in one cycle cancel out.
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        valid_next = 1'b0;
        case (state_reg)
            SELECT: begin
                if (press[BTN_CONFIRM]) begin
                    state_next = LOCKED;
                    valid_next = 1'b1;
                end else if (press[BTN_NEXT] && !press[BTN_PREV]) begin
                    sel_next = (sel_reg >= SEL_LAST) ? 3'd0 : sel_reg + 3'd1;
                end else if (press[BTN_PREV] && !press[BTN_NEXT]) begin
                    sel_next = (sel_reg == 3'd0 || sel_reg > SEL_LAST) ? SEL_LAST : sel_reg - 3'd1;
                end
            end
            LOCKED: begin
                if (bus.clear) begin
                    state_next = SELECT;
                end
            end
            default: begin
                state_next = SELECT;
            end
        endcase
    end

    assign bus.method_sel   = sel_reg;
    assign bus.method_valid = valid_reg;
    assign bus.locked       = (state_reg == LOCKED);

endmodule
